// File: rtl/dpu_sequencer.sv
// dpu_sequencer: microcoded sequencer for the 4-register-address DPU.
// Fetches 16-bit instructions from a synchronous ROM and drives the DPU
// control buses. It also runs data-memory loads over a req/ack handshake,
// takes branches on the DPU condition codes and toggles outEnable for video.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; pc parked
// FETCH    | imem_addr = pc, ROM read in flight
// DECODE   | imem_data valid; dispatch on op
// EXEC     | ALU op held on the buses for EXEC_CYCLES cycles
// LOAD_REQ | mem_req held until mem_ack or timeout
// LOAD_WR  | loaded byte on mData, n_op = 8 for one cycle
// VIDEO    | toggle out_enable
// HALT     | done pulse visible, busy low, start ignored
// ERROR    | load timed out; wait for start
module dpu_sequencer #(
  parameter int         PC_W        = 8,
  parameter logic [3:0] IDLE_OP     = 4'd15,
  parameter int         EXEC_CYCLES = 2,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic            mem_req,
  output logic [7:0]      mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [3:0]      a_bus,
  output logic [3:0]      b_bus,
  output logic [3:0]      r_bus,
  output logic [3:0]      n_op,
  output logic [7:0]      m_data,
  output logic            out_enable,
  input  logic [3:0]      cc
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LOAD_REQ,
    S_LOAD_WR, S_VIDEO, S_HALT, S_ERROR
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'd8;
  localparam logic [3:0] OP_BRANCH = 4'd14;
  localparam logic [3:0] OP_CTRL   = 4'd15;

  // One down-counter serves both the EXEC hold and the load timeout;
  // the two never overlap. Terminal count is zero.
  localparam logic [7:0] EXEC_LOAD = 8'(EXEC_CYCLES - 1);
  localparam logic [7:0] TMO_LOAD  = 8'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      ir_r_q, ir_r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            mem_req_q, mem_req_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [3:0]      a_q, a_d, b_q, b_d, r_q, r_d, n_q, n_d;
  logic [7:0]      m_q, m_d;
  logic            oe_q, oe_d;

  logic [3:0]      f_op, f_r, f_a, f_b;
  logic [7:0]      f_imm;
  logic [PC_W-1:0] pc_inc, pc_imm;

  assign f_op   = imem_data[15:12];
  assign f_r    = imem_data[11:8];
  assign f_a    = imem_data[7:4];
  assign f_b    = imem_data[3:0];
  assign f_imm  = imem_data[7:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_imm = PC_W'(f_imm);

  // State and output registers; synchronous reset to the idle bus values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      ir_r_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      n_q        <= IDLE_OP;
      m_q        <= '0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ir_r_q     <= ir_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      n_q        <= n_d;
      m_q        <= m_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ir_r_d     = ir_r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    n_d        = n_q;
    m_d        = m_q;
    oe_d       = oe_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          pc_d    = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_r_d = f_r;
        case (f_op)
          OP_LOAD: begin
            mem_req_d  = 1'b1;
            mem_addr_d = f_imm;
            cnt_d      = TMO_LOAD;
            state_d    = S_LOAD_REQ;
          end
          OP_BRANCH: begin
            pc_d    = ((cc & f_r) != 4'd0) ? pc_imm : pc_inc;
            state_d = S_FETCH;
          end
          OP_CTRL: begin
            case (f_r)
              4'd0: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_HALT;
              end
              4'd1: state_d = S_VIDEO;
              4'd2: begin
                pc_d    = pc_imm;
                state_d = S_FETCH;
              end
              default: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end
            endcase
          end
          default: begin
            a_d     = f_a;
            b_d     = f_b;
            r_d     = f_r;
            n_d     = f_op;
            cnt_d   = EXEC_LOAD;
            state_d = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        if (cnt_q == 8'd0) begin
          n_d     = IDLE_OP;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOAD_REQ: begin
        // An ack on the terminal-count cycle still wins over the timeout.
        if (mem_ack) begin
          m_d       = mem_rdata;
          mem_req_d = 1'b0;
          r_d       = ir_r_q;
          n_d       = OP_LOAD;
          state_d   = S_LOAD_WR;
        end else if (cnt_q == 8'd0) begin
          mem_req_d = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_ERROR;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOAD_WR: begin
        n_d     = IDLE_OP;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_VIDEO: begin
        oe_d    = ~oe_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign a_bus      = a_q;
  assign b_bus      = b_q;
  assign r_bus      = r_q;
  assign n_op       = n_q;
  assign m_data     = m_q;
  assign out_enable = oe_q;

endmodule
